// File: rtl/pong_pkg.sv
// Shared definitions for the pong paddle input path.
//   POS_W        : width of a paddle row number
//   PADDLE_MAX   : highest legal paddle row
//   PADDLE_RESET : row loaded after reset or a recenter request
//   acc_t        : signed sub-step accumulator (holds -DETENT..+DETENT)
//   enc_state_t  : decoder FSM states
//   gray_to_idx  : maps a quadrature pair {a,b} to its position in the
//                  forward cycle 00->01->11->10
package pong_pkg;

    localparam int POS_W        = 5;
    localparam int PADDLE_MAX   = 28;
    localparam int PADDLE_RESET = 14;
    localparam int ACC_W        = 4;

    typedef logic [POS_W-1:0]        position_t;
    typedef logic signed [ACC_W-1:0] acc_t;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } enc_state_t;

    // Gray-to-binary: 00->0, 01->1, 11->2, 10->3, so a forward step is
    // always index+1 modulo 4.
    function automatic logic [1:0] gray_to_idx(input logic [1:0] ab);
        return {ab[1], ab[1] ^ ab[0]};
    endfunction

endpackage

// File: rtl/paddle_encoder_if.sv
// Signal bundle between a quadrature paddle and its encoder block.
//   enc_a, enc_b : raw asynchronous encoder phases
//   recenter     : synchronous request to reload the reset row
//   position     : registered paddle row
//   moved        : one-cycle pulse when position stepped
//   dir          : direction of the last step (1 = increment)
//   glitch       : one-cycle pulse on an illegal quadrature transition
// master drives the encoder inputs, slave is the encoder block.
interface paddle_encoder_if;
    import pong_pkg::*;

    logic      enc_a;
    logic      enc_b;
    logic      recenter;
    position_t position;
    logic      moved;
    logic      dir;
    logic      glitch;

    modport master (
        output enc_a, enc_b, recenter,
        input  position, moved, dir, glitch
    );

    modport slave (
        input  enc_a, enc_b, recenter,
        output position, moved, dir, glitch
    );

endinterface

// File: rtl/debounce.sv
// One encoder phase: 2-flop synchronizer followed by a debouncer.
//   clk    : clock
//   srst   : synchronous active-high reset
//   raw    : asynchronous input phase
//   load   : force stable to the synchronized value and clear the counter
//   sync   : synchronized (not debounced) phase
//   stable : debounced phase; follows sync only after it has differed
//            for CYCLES consecutive cycles
module debounce #(
    parameter int CYCLES = 1024
) (
    input  logic clk,
    input  logic srst,
    input  logic raw,
    input  logic load,
    output logic sync,
    output logic stable
);

    localparam logic [15:0] CNT_LAST = 16'(CYCLES - 1);

    logic [1:0]  sync_reg;
    logic [15:0] cnt_reg;
    logic [15:0] cnt_next;
    logic        stable_reg;
    logic        stable_next;

    // Counter only runs while sync disagrees with stable; any agreement
    // (including a reversion of the input) drops it back to zero.
    always_comb begin
        cnt_next    = '0;
        stable_next = stable_reg;
        if (load) begin
            stable_next = sync_reg[1];
        end else if (sync_reg[1] != stable_reg) begin
            if (cnt_reg == CNT_LAST) begin
                stable_next = sync_reg[1];
            end else begin
                cnt_next = cnt_reg + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            sync_reg   <= '0;
            cnt_reg    <= '0;
            stable_reg <= 1'b0;
        end else begin
            sync_reg   <= {sync_reg[0], raw};
            cnt_reg    <= cnt_next;
            stable_reg <= stable_next;
        end
    end

    assign sync   = sync_reg[1];
    assign stable = stable_reg;

endmodule

// File: rtl/paddle_encoder.sv
// Quadrature paddle encoder: synchronizes and debounces both phases,
// decodes Gray transitions into a sub-step accumulator, and steps a
// saturating paddle row every DETENT transitions.
//   clk32mhz : sole clock, rising edge
//   reset    : synchronous active-high reset
//   bus      : paddle_encoder_if.slave (enc_a/enc_b/recenter in,
//              position/moved/dir/glitch out)
// Parameters: DEBOUNCE_CYCLES (2..65535), DETENT (1, 2 or 4),
//             PADDLE_MAX, PADDLE_RESET.
module paddle_encoder #(
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int DETENT          = 4,
    parameter int PADDLE_MAX      = pong_pkg::PADDLE_MAX,
    parameter int PADDLE_RESET    = pong_pkg::PADDLE_RESET
) (
    input logic             clk32mhz,
    input logic             reset,
    paddle_encoder_if.slave bus
);
    import pong_pkg::*;

    localparam logic [1:0] INIT_LAST  = 2'd2;
    localparam position_t  MAX_POS    = position_t'(PADDLE_MAX);
    localparam position_t  RESET_POS  = position_t'(PADDLE_RESET);
    localparam acc_t       DETENT_POS = acc_t'(DETENT);
    localparam acc_t       DETENT_NEG = acc_t'(-DETENT);

    // ---------------------------------------------------------------
    // Per-phase synchronizer + debouncer; index 1 = A, index 0 = B
    // ---------------------------------------------------------------
    logic [1:0] raw_vec;
    logic [1:0] sync_vec;
    logic [1:0] stable_vec;
    logic       load_stable;

    assign raw_vec = {bus.enc_a, bus.enc_b};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_phase
            debounce #(
                .CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk    (clk32mhz),
                .srst   (reset),
                .raw    (raw_vec[gi]),
                .load   (load_stable),
                .sync   (sync_vec[gi]),
                .stable (stable_vec[gi])
            );
        end
    endgenerate

    // ---------------------------------------------------------------
    // Decoder FSM: INIT waits 3 cycles for the synchronizers to fill,
    // then seeds stable/previous state from the live inputs.
    // ---------------------------------------------------------------
    enc_state_t state_reg;
    enc_state_t state_next;
    logic [1:0] init_cnt_reg;
    logic [1:0] init_cnt_next;
    logic       run_en;

    always_ff @(posedge clk32mhz) begin
        if (reset) begin
            state_reg    <= ST_INIT;
            init_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            init_cnt_reg <= init_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        init_cnt_next = '0;
        case (state_reg)
            ST_INIT: begin
                init_cnt_next = init_cnt_reg + 2'd1;
                if (init_cnt_reg == INIT_LAST) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_INIT;
        endcase
    end

    always_comb begin
        load_stable = 1'b0;
        run_en      = 1'b0;
        case (state_reg)
            ST_INIT: load_stable = (init_cnt_reg == INIT_LAST);
            ST_RUN:  run_en      = 1'b1;
            default: ;
        endcase
    end

    // ---------------------------------------------------------------
    // Transition decode and position datapath
    // ---------------------------------------------------------------
    logic [1:0] prev_reg,  prev_next;
    acc_t       acc_reg,   acc_next;
    position_t  pos_reg,   pos_next;
    logic       dir_reg,   dir_next;
    logic       moved_reg, moved_next;
    logic       glitch_reg, glitch_next;

    logic [1:0] changed;
    logic       one_change;
    logic       both_change;
    logic       fwd;
    acc_t       acc_sum;
    logic       hit_up;
    logic       hit_dn;

    assign changed     = stable_vec ^ prev_reg;
    assign both_change = &changed;
    assign one_change  = ^changed;
    // With exactly one phase changed the index moves by +/-1 only.
    assign fwd         = (gray_to_idx(stable_vec) == (gray_to_idx(prev_reg) + 2'd1));
    assign acc_sum     = fwd ? (acc_reg + acc_t'(1)) : (acc_reg - acc_t'(1));
    assign hit_up      = one_change && (acc_sum == DETENT_POS);
    assign hit_dn      = one_change && (acc_sum == DETENT_NEG);

    // A step requires exactly one changed phase and a glitch requires
    // both, so moved and glitch can never coincide.
    always_comb begin
        prev_next   = prev_reg;
        acc_next    = acc_reg;
        pos_next    = pos_reg;
        dir_next    = dir_reg;
        moved_next  = 1'b0;
        glitch_next = 1'b0;
        if (load_stable) begin
            prev_next = sync_vec;
        end else if (run_en) begin
            prev_next   = stable_vec;
            glitch_next = both_change;
            if (bus.recenter) begin
                // Recenter wins over a step completing in the same cycle.
                pos_next = RESET_POS;
                acc_next = '0;
            end else if (hit_up) begin
                acc_next = '0;
                if (pos_reg < MAX_POS) begin
                    pos_next   = pos_reg + position_t'(1);
                    dir_next   = 1'b1;
                    moved_next = 1'b1;
                end
            end else if (hit_dn) begin
                acc_next = '0;
                if (pos_reg != '0) begin
                    pos_next   = pos_reg - position_t'(1);
                    dir_next   = 1'b0;
                    moved_next = 1'b1;
                end
            end else if (one_change) begin
                acc_next = acc_sum;
            end
        end
    end

    always_ff @(posedge clk32mhz) begin
        if (reset) begin
            prev_reg   <= '0;
            acc_reg    <= '0;
            pos_reg    <= RESET_POS;
            dir_reg    <= 1'b1;
            moved_reg  <= 1'b0;
            glitch_reg <= 1'b0;
        end else begin
            prev_reg   <= prev_next;
            acc_reg    <= acc_next;
            pos_reg    <= pos_next;
            dir_reg    <= dir_next;
            moved_reg  <= moved_next;
            glitch_reg <= glitch_next;
        end
    end

    assign bus.position = pos_reg;
    assign bus.moved    = moved_reg;
    assign bus.dir      = dir_reg;
    assign bus.glitch   = glitch_reg;

endmodule

// File: tb/tb_paddle_encoder.sv
// Directed bench for paddle_encoder (DEBOUNCE_CYCLES=4, DETENT=4,
// PADDLE_MAX=28, PADDLE_RESET=14). Stimulus pushes expected moved/glitch
// pulses (row, dir, cycle) into a queue; a negedge monitor pops and
// compares every pulse the design emits.
module tb_paddle_encoder;

    localparam int DEB  = 4;
    localparam int DET  = 4;
    localparam int LAT  = DEB + 3;
    localparam int HOLD = 10;

    typedef struct {
        bit         is_glitch;
        logic [4:0] pos;
        logic       dir;
        int         cyc;
    } exp_t;

    logic clk32mhz = 1'b0;
    logic reset;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    paddle_encoder_if bus ();

    paddle_encoder #(
        .DEBOUNCE_CYCLES (DEB),
        .DETENT          (DET),
        .PADDLE_MAX      (28),
        .PADDLE_RESET    (14)
    ) dut (
        .clk32mhz (clk32mhz),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 clk32mhz = ~clk32mhz;
    always @(posedge clk32mhz) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("chk  %-22s = %0d ok (cycle %0d)", name, act, cyc);
        end
    endtask

    // kind: 0 = no pulse expected, 1 = moved, 2 = glitch
    task automatic put_ab(input logic [1:0] ab, input int kind,
                          input logic [4:0] pos, input logic d);
        exp_t e;
        @(posedge clk32mhz);
        #1;
        bus.enc_a = ab[1];
        bus.enc_b = ab[0];
        if (kind != 0) begin
            e.is_glitch = (kind == 2);
            e.pos       = pos;
            e.dir       = d;
            e.cyc       = cyc + LAT;
            exp_q.push_back(e);
        end
        repeat (HOLD - 1) @(posedge clk32mhz);
    endtask

    // One full detent starting and ending at 11.
    task automatic detent(input bit cw, input bit exp_move, input logic [4:0] pos);
        logic [1:0] seq [4];
        if (cw) seq = '{2'b10, 2'b00, 2'b01, 2'b11};
        else    seq = '{2'b01, 2'b00, 2'b10, 2'b11};
        for (int i = 0; i < 3; i++) put_ab(seq[i], 0, 5'd0, 1'b0);
        put_ab(seq[3], exp_move ? 1 : 0, pos, cw);
    endtask

    task automatic do_recenter();
        @(posedge clk32mhz);
        #1 bus.recenter = 1'b1;
        @(posedge clk32mhz);
        #1 bus.recenter = 1'b0;
    endtask

    // Monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk32mhz);
            if (bus.moved && bus.glitch) begin
                n_vec++;
                n_err++;
                $display("FAIL moved_and_glitch: both high at cycle %0d, want at most one", cyc);
            end else if (bus.moved || bus.glitch) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_pulse: glitch=%0d moved=%0d pos=%0d dir=%0d at cycle %0d, want no pulse",
                             bus.glitch, bus.moved, bus.position, bus.dir, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.glitch != e.is_glitch || bus.position != e.pos ||
                        bus.dir != e.dir || cyc != e.cyc) begin
                        n_err++;
                        $display("FAIL pulse: glitch=%0d pos=%0d dir=%0d cycle=%0d, want glitch=%0d pos=%0d dir=%0d cycle=%0d",
                                 bus.glitch, bus.position, bus.dir, cyc,
                                 e.is_glitch, e.pos, e.dir, e.cyc);
                    end else begin
                        $display("txn  %s pos=%0d dir=%0d cycle=%0d ok",
                                 e.is_glitch ? "glitch" : "moved ", e.pos, e.dir, cyc);
                    end
                end
            end
        end
    end

    initial begin
        reset        = 1'b1;
        bus.enc_a    = 1'b1;
        bus.enc_b    = 1'b1;
        bus.recenter = 1'b0;

        // Reset values and idle-at-11 start-up
        repeat (4) @(posedge clk32mhz);
        #1;
        check("reset_position", int'(bus.position), 14);
        check("reset_dir",      int'(bus.dir),      1);
        check("reset_moved",    int'(bus.moved),    0);
        check("reset_glitch",   int'(bus.glitch),   0);
        reset = 1'b0;
        repeat (12) @(posedge clk32mhz);
        #1;
        check("init_position", int'(bus.position), 14);

        // 3-cycle pulse on A is rejected by the debouncer
        @(posedge clk32mhz);
        #1 bus.enc_a = 1'b0;
        repeat (3) @(posedge clk32mhz);
        #1 bus.enc_a = 1'b1;
        repeat (HOLD) @(posedge clk32mhz);
        #1;
        check("short_pulse_position", int'(bus.position), 14);

        // One clean CW detent; step only on the 4th transition
        detent(1'b1, 1'b1, 5'd15);
        #1;
        check("cw_position", int'(bus.position), 15);
        check("cw_dir",      int'(bus.dir),      1);

        // Recenter, then one CCW detent
        do_recenter();
        check("recenter_position", int'(bus.position), 14);
        detent(1'b0, 1'b1, 5'd13);
        #1;
        check("ccw_dir", int'(bus.dir), 0);

        // 20 CCW detents from 14: 14 steps then saturation at 0
        do_recenter();
        for (int i = 0; i < 20; i++) detent(1'b0, i < 14, 5'(13 - i));
        #1;
        check("sat_low_position", int'(bus.position), 0);
        check("sat_low_dir",      int'(bus.dir),      0);

        // 20 CW detents from 14: saturation at 28
        do_recenter();
        check("recenter_keeps_dir", int'(bus.dir), 0);
        for (int i = 0; i < 20; i++) detent(1'b1, i < 14, 5'(15 + i));
        #1;
        check("sat_high_position", int'(bus.position), 28);
        check("sat_high_dir",      int'(bus.dir),      1);

        // Both phases toggled together: glitch, no step
        do_recenter();
        put_ab(2'b00, 2, 5'd14, 1'b1);
        put_ab(2'b11, 2, 5'd14, 1'b1);
        #1;
        check("glitch_position", int'(bus.position), 14);

        // Recenter in the cycle a step completes
        detent(1'b1, 1'b1, 5'd15);
        put_ab(2'b10, 0, 5'd0, 1'b0);
        put_ab(2'b00, 0, 5'd0, 1'b0);
        put_ab(2'b01, 0, 5'd0, 1'b0);
        @(posedge clk32mhz);
        #1;
        bus.enc_a = 1'b1;
        bus.enc_b = 1'b1;
        repeat (LAT - 1) @(posedge clk32mhz);
        #1 bus.recenter = 1'b1;
        @(posedge clk32mhz);
        #1 bus.recenter = 1'b0;
        check("recenter_vs_step_pos",   int'(bus.position), 14);
        check("recenter_vs_step_moved", int'(bus.moved),    0);
        repeat (HOLD) @(posedge clk32mhz);
        detent(1'b1, 1'b1, 5'd15);

        // Reset mid-detent and mid-debounce discards partial progress
        put_ab(2'b10, 0, 5'd0, 1'b0);
        put_ab(2'b00, 0, 5'd0, 1'b0);
        @(posedge clk32mhz);
        #1;
        bus.enc_a = 1'b0;
        bus.enc_b = 1'b1;
        repeat (2) @(posedge clk32mhz);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk32mhz);
        #1 reset = 1'b0;
        repeat (12) @(posedge clk32mhz);
        #1;
        check("mid_reset_position", int'(bus.position), 14);
        put_ab(2'b11, 0, 5'd0, 1'b0);
        put_ab(2'b10, 0, 5'd0, 1'b0);
        put_ab(2'b00, 0, 5'd0, 1'b0);
        put_ab(2'b01, 1, 5'd15, 1'b1);

        repeat (20) @(posedge clk32mhz);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
